// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/execute control unit for the 6-bit CPU
//
// Owns the 3-bit program counter and the 6-bit instruction register and
// steps IDLE -> FETCH -> DECODE -> EXEC -> FETCH ... until a HLT parks it
// in HALT (left only by reset). Datapath strobes are combinational decodes
// of the registered state and instruction, so they clear together with the
// asynchronous reset.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  level, leaves IDLE when high
//   stall   in   1  freezes FETCH/DECODE/EXEC, suppresses strobes
//   instr   in   6  instruction memory data at pc ([5:3] opcode, [2:0] imm)
//   zero    in   1  accumulator-zero flag, sampled by JZ in EXEC
//   pc      out  3  program counter
//   ir      out  6  instruction register
//   imm     out  3  ir[2:0]
//   alu_op  out  2  00 pass-imm, 01 add, 10 sub (00 when acc_we is low)
//   acc_we  out  1  accumulator write strobe
//   out_we  out  1  output-port write strobe
//   busy    out  1  in FETCH, DECODE or EXEC
//   halted  out  1  in HALT

module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic [5:0] instr,
  input  logic       zero,
  output logic [2:0] pc,
  output logic [5:0] ir,
  output logic [2:0] imm,
  output logic [1:0] alu_op,
  output logic       acc_we,
  output logic       out_we,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_OUT = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  state_t     state_q, state_d;
  logic [2:0] pc_q, pc_d;
  logic [5:0] ir_q, ir_d;
  logic [2:0] pc_inc;

  // 3-bit add wraps 7 -> 0 naturally.
  assign pc_inc = pc_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= 3'd0;
      ir_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_we  = 1'b0;
    out_we  = 1'b0;
    alu_op  = ALU_PASS;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (!stall) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!stall) state_d = S_EXEC;
      end

      // A stalled EXEC does nothing at all, so the action fires exactly once,
      // in the first unstalled EXEC cycle, with zero sampled in that cycle.
      S_EXEC: begin
        if (!stall) begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
          case (ir_q[5:3])
            OP_NOP: ;
            OP_LDI: begin
              acc_we = 1'b1;
              alu_op = ALU_PASS;
            end
            OP_ADD: begin
              acc_we = 1'b1;
              alu_op = ALU_ADD;
            end
            OP_SUB: begin
              acc_we = 1'b1;
              alu_op = ALU_SUB;
            end
            OP_JMP: pc_d = ir_q[2:0];
            OP_JZ:  pc_d = zero ? ir_q[2:0] : pc_inc;
            OP_OUT: out_we = 1'b1;
            OP_HLT: begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end
          endcase
        end
      end

      S_HALT: ;

      default: state_d = S_IDLE;
    endcase
  end

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign imm    = ir_q[2:0];
  assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic [5:0] instr;
  logic       zero;
  logic [2:0] pc;
  logic [5:0] ir;
  logic [2:0] imm;
  logic [1:0] alu_op;
  logic       acc_we;
  logic       out_we;
  logic       busy;
  logic       halted;

  logic [5:0] mem [8];
  assign instr = mem[pc];

  pc_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stall  (stall),
    .instr  (instr),
    .zero   (zero),
    .pc     (pc),
    .ir     (ir),
    .imm    (imm),
    .alu_op (alu_op),
    .acc_we (acc_we),
    .out_we (out_we),
    .busy   (busy),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected strobe: {acc_we, out_we, alu_op, pc, cycle relative to start}
  typedef struct packed {
    logic       acc;
    logic       out;
    logic [1:0] op;
    logic [2:0] pc;
    logic [7:0] rel;
  } strobe_t;

  strobe_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic strobe_t mk(input logic a, input logic o, input logic [1:0] op,
                                 input logic [2:0] p, input logic [7:0] r);
    strobe_t s;
    s.acc = a; s.out = o; s.op = op; s.pc = p; s.rel = r;
    return s;
  endfunction

  // Monitor: every strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    strobe_t obs;
    strobe_t e;
    logic [7:0] r8;
    r8 = 8'(cyc - t0);
    obs = mk(acc_we, out_we, alu_op, pc, r8);
    if (acc_we || out_we) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(obs), 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe", 32'(obs), 32'(e));
      end
    end
    if (!acc_we) check("alu_op_idle", 32'(alu_op), 32'd0);
    check("imm", 32'(imm), 32'(ir[2:0]));
  end

  task automatic load_nops();
    for (int i = 0; i < 8; i++) mem[i] = 6'b000_000;
  endtask

  task automatic apply_reset();
    start = 1'b0;
    stall = 1'b0;
    zero  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of relative cycle 1 (the first FETCH).
  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic run_branch(input string tag, input logic [5:0] op, input logic z,
                            input logic [2:0] exp_pc);
    load_nops();
    mem[2] = op;
    apply_reset();
    zero = z;
    start_run();
    repeat (9) @(negedge clk);
    check(tag, 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    zero  = 1'b0;
    load_nops();

    // Reset and straight-line program: LDI 3, ADD 2, OUT, HLT
    mem[0] = 6'b001_011;
    mem[1] = 6'b010_010;
    mem[2] = 6'b110_000;
    mem[3] = 6'b111_000;
    apply_reset();
    repeat (5) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_strobes", 32'({acc_we, out_we}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    sb.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 8'd3));
    sb.push_back(mk(1'b1, 1'b0, 2'b01, 3'd1, 8'd6));
    sb.push_back(mk(1'b0, 1'b1, 2'b00, 3'd2, 8'd9));
    start_run();
    check("start_busy", 32'(busy), 32'd1);
    check("fetch_ir_old", 32'(ir), 32'd0);
    @(negedge clk);
    check("fetch_ir_loaded", 32'(ir), 32'(6'b001_011));
    repeat (10) @(negedge clk);
    check("halted_c12", 32'(halted), 32'd0);
    @(negedge clk);
    check("halted_c13", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd3);
    check("halt_busy", 32'(busy), 32'd0);
    start = 1'b1;
    stall = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_sticky_pc", 32'(pc), 32'd3);
    check("sb_drain_line", 32'(sb.size()), 32'd0);

    // Wrap-around: eight NOPs
    load_nops();
    apply_reset();
    start_run();
    for (int k = 1; k <= 8; k++) begin
      repeat (3) @(negedge clk);
      check("wrap_pc", 32'(pc), 32'(k % 8));
    end
    check("sb_drain_wrap", 32'(sb.size()), 32'd0);

    // Branches at pc=2
    run_branch("jz_taken", 6'b101_101, 1'b1, 3'd5);
    run_branch("jz_not_taken", 6'b101_101, 1'b0, 3'd3);
    run_branch("jmp", 6'b100_110, 1'b0, 3'd6);
    run_branch("jmp_self", 6'b100_010, 1'b0, 3'd2);
    repeat (3) @(negedge clk);
    check("jmp_self_loop", 32'(pc), 32'd2);

    // Stall across four EXEC cycles of ADD
    load_nops();
    mem[0] = 6'b001_001;
    mem[1] = 6'b010_010;
    mem[2] = 6'b111_000;
    apply_reset();
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 8'd3));
    sb.push_back(mk(1'b1, 1'b0, 2'b01, 3'd1, 8'd10));
    start_run();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_acc_we", 32'(acc_we), 32'd0);
      check("stall_pc", 32'(pc), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stall_pc_after", 32'(pc), 32'd2);
    repeat (3) @(negedge clk);
    check("stall_halted", 32'(halted), 32'd1);
    check("sb_drain_stall", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of OUT's EXEC cycle
    load_nops();
    mem[0] = 6'b000_111;
    mem[1] = 6'b110_000;
    apply_reset();
    sb.push_back(mk(1'b0, 1'b1, 2'b00, 3'd1, 8'd6));
    start_run();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_we", 32'(out_we), 32'd0);
    check("arst_pc", 32'(pc), 32'd0);
    check("arst_ir", 32'(ir), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("sb_drain_arst", 32'(sb.size()), 32'd0);
    start_run();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_pc", 32'(pc), 32'd0);
    @(negedge clk);
    check("restart_ir", 32'(ir), 32'(6'b000_111));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control unit for the 6-bit CPU. It owns the 3-bit program counter and the 6-bit instruction register, and steps a fetch/decode/execute state machine. It issues one-cycle datapath strobes (ALU op, accumulator write, output-port write) and computes the next PC: increment with wrap-around, unconditional jump, or jump-if-zero. It sits between instruction memory (addressed by `pc`) and the accumulator/ALU datapath.

## Interface
- No parameters. Widths are fixed: PC is 3 bits, instruction is 6 bits (`[5:3]` opcode, `[2:0]` immediate).
- Reset is asynchronous and active-low.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level; leaves IDLE when high.
- `stall`  in  1  holds FETCH/DECODE/EXEC state and all registers while high.
- `instr`  in  6  instruction memory data for the current `pc` (combinational memory).
- `zero`  in  1  accumulator-zero flag from the datapath.
- `pc`  out  3  program counter, registered.
- `ir`  out  6  instruction register, registered.
- `imm`  out  3  equals `ir[2:0]`.
- `alu_op`  out  2  00 pass-imm, 01 add, 10 sub; valid while `acc_we` is high.
- `acc_we`  out  1  one-cycle accumulator write strobe.
- `out_we`  out  1  one-cycle output-port write strobe.
- `busy`  out  1  high in FETCH, DECODE and EXEC.
- `halted`  out  1  high in HALT.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, HALT. Reset enters IDLE.
- **IDLE:**
  - if `start`=1, go to FETCH next cycle; else remain in IDLE.
  - `stall` is ignored in IDLE.
- **FETCH:** `ir <= instr`, then go to DECODE.
- **DECODE:** no register change; go to EXEC.
- **EXEC:** act on `ir[5:3]`, then go to FETCH (except HLT).
  - 000 NOP: `pc <= pc+1`.
  - 001 LDI: `acc_we`=1, `alu_op`=00, `pc <= pc+1`.
  - 010 ADD: `acc_we`=1, `alu_op`=01, `pc <= pc+1`.
  - 011 SUB: `acc_we`=1, `alu_op`=10, `pc <= pc+1`.
  - 100 JMP: `pc <= imm`.
  - 101 JZ: `pc <= zero ? imm : pc+1`; `zero` is sampled in the EXEC cycle.
  - 110 OUT: `out_we`=1, `pc <= pc+1`.
  - 111 HLT: `pc` unchanged; go to HALT.
- **Increment rule:** `pc+1` is modulo 8, so 7 wraps to 0.
- **Stall:**
  - In FETCH, DECODE or EXEC with `stall`=1: state, `pc` and `ir` hold.
  - `acc_we` and `out_we` are forced to 0.
  - The EXEC action executes exactly once, in the first EXEC cycle with `stall`=0.
- **HALT:** sticky. `halted`=1 and `busy`=0; `start` and `stall` are ignored. Only `rst_n` exits.
- **Strobes:** `acc_we` and `out_we` are combinational decodes of state plus `ir`. Each is high only in an unstalled EXEC cycle.
- **`alu_op`:** 00 whenever `acc_we`=0.

## Timing
- **Reset values:** state IDLE; `pc`=000, `ir`=000000, `imm`=000, `alu_op`=00; `acc_we`, `out_we`, `busy`, `halted` all 0.
- **Reset response:** `rst_n` low takes effect immediately, regardless of `clk` or current state, including mid-EXEC. Strobes drop in the same instant.
- **Cycles per instruction:** exactly 3 with no stall (FETCH, DECODE, EXEC). Each stalled cycle adds one.
- **Start latency:** `start` sampled high at edge N gives FETCH during cycle N+1. The first strobe can appear in cycle N+3.
- **Instruction memory:** `instr` must be valid during FETCH for the current `pc`. The new `pc` is visible in the cycle after EXEC, which is the next FETCH.
- **Simultaneous events:**
  - `stall` and EXEC together: the stall wins.
  - JZ with `zero` changing mid-stall: the value in the unstalled EXEC cycle is used.
  - JMP to the current `pc` gives a legal infinite loop.

## Test plan
- **Reset and start:** reset, hold `start`=0 for 5 cycles -> IDLE, `pc`=0, all outputs 0. Pulse `start` -> `busy`=1 next cycle; `ir` loads memory[0] one cycle later.
- **Straight-line program:** program LDI 3, ADD 2, OUT, HLT.
  - `acc_we` at cycles 3 and 6 with `alu_op` 00 then 01.
  - `out_we` at cycle 9.
  - `halted`=1 at cycle 13 with `pc`=3.
  - Thereafter `halted` stays 1 regardless of `start`.
- **Wrap-around:** 8 NOPs from `pc`=0 -> `pc` sequence 1..7, then 0; no strobes.
- **Branches:**
  - JZ 5 at `pc`=2 with `zero`=1 -> `pc`=5.
  - Same with `zero`=0 -> `pc`=3.
  - JMP 6 -> `pc`=6.
- **Stall:** hold `stall`=1 for 4 cycles during EXEC of ADD -> `acc_we` low throughout the stall. Exactly one `acc_we` pulse follows on release; `pc` advances once.
- **Reset mid-operation:** drop `rst_n` mid-EXEC of OUT, between clock edges -> `out_we`, `pc`, `ir` and state clear immediately. Restart fetches from `pc`=0.
